jtag_tap_ctrl: RTL

Device-side IEEE 1149.1 TAP controller that sits directly downstream of the JTAG pins (tck/tms/tdi/tdo/tdo_oe). It implements the 16-state TAP FSM, an instruction register, IDCODE and BYPASS data registers, and the TDO output stage. It exposes one user data-register port so a downstream register, such as a debug-module interface, can be captured, shifted and updated.

---
 rtl/jtag_pkg.sv | 47 ++++
 rtl/jtag_tap_fsm.sv | 38 +++
 rtl/jtag_tap_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encodings, next-state function and IR capture constant
package jtag_pkg;

    typedef enum logic [3:0] {
        Exit2Dr        = 4'h0,
        Exit1Dr        = 4'h1,
        ShiftDr        = 4'h2,
        PauseDr        = 4'h3,
        SelectIr       = 4'h4,
        UpdateDr       = 4'h5,
        CaptureDr      = 4'h6,
        SelectDr       = 4'h7,
        Exit2Ir        = 4'h8,
        Exit1Ir        = 4'h9,
        ShiftIr        = 4'hA,
        PauseIr        = 4'hB,
        RunTestIdle    = 4'hC,
        UpdateIr       = 4'hD,
        CaptureIr      = 4'hE,
        TestLogicReset = 4'hF
    } tap_state_e;

    localparam logic [1:0] IrCaptureValue = 2'b01;

    function automatic tap_state_e tap_next_state(input tap_state_e state, input logic tms);
        tap_next_state = TestLogicReset;
        case (state)
            TestLogicReset: tap_next_state = tms ? TestLogicReset : RunTestIdle;
            RunTestIdle:    tap_next_state = tms ? SelectDr : RunTestIdle;
            SelectDr:       tap_next_state = tms ? SelectIr : CaptureDr;
            CaptureDr:      tap_next_state = tms ? Exit1Dr : ShiftDr;
            ShiftDr:        tap_next_state = tms ? Exit1Dr : ShiftDr;
            Exit1Dr:        tap_next_state = tms ? UpdateDr : PauseDr;
            PauseDr:        tap_next_state = tms ? Exit2Dr : PauseDr;
            Exit2Dr:        tap_next_state = tms ? UpdateDr : ShiftDr;
            UpdateDr:       tap_next_state = tms ? SelectDr : RunTestIdle;
            SelectIr:       tap_next_state = tms ? TestLogicReset : CaptureIr;
            CaptureIr:      tap_next_state = tms ? Exit1Ir : ShiftIr;
            ShiftIr:        tap_next_state = tms ? Exit1Ir : ShiftIr;
            Exit1Ir:        tap_next_state = tms ? UpdateIr : PauseIr;
            PauseIr:        tap_next_state = tms ? Exit2Ir : PauseIr;
            Exit2Ir:        tap_next_state = tms ? UpdateIr : ShiftIr;
            UpdateIr:       tap_next_state = tms ? SelectDr : RunTestIdle;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state TAP state register with one-hot state decodes
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck_i,
    input  logic       trst_ni,
    input  logic       tms_i,
    output logic [3:0] tap_state_o,
    output logic       reset_next_o,
    output logic       capture_dr_o,
    output logic       shift_dr_o,
    output logic       update_dr_o,
    output logic       capture_ir_o,
    output logic       shift_ir_o,
    output logic       update_ir_o
);

    tap_state_e state_q, state_d;

    always_comb begin
        state_d = tap_next_state(state_q, tms_i);
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) state_q <= TestLogicReset;
        else          state_q <= state_d;
    end

    assign tap_state_o  = state_q;
    assign reset_next_o = state_d == TestLogicReset;
    assign capture_dr_o = state_q == CaptureDr;
    assign shift_dr_o   = state_q == ShiftDr;
    assign update_dr_o  = state_q == UpdateDr;
    assign capture_ir_o = state_q == CaptureIr;
    assign shift_ir_o   = state_q == ShiftIr;
    assign update_ir_o  = state_q == UpdateIr;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP with IR, IDCODE, BYPASS, a user DR port
// and a negedge-registered TDO stage.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned        IrWidth     = 5,
    parameter logic [31:0]        IdcodeValue = 32'h0000_0001,
    parameter logic [IrWidth-1:0] IdcodeIr    = IrWidth'('h01),
    parameter logic [IrWidth-1:0] UserIr      = IrWidth'('h11)
) (
    input  logic               tck_i,
    input  logic               trst_ni,
    input  logic               tms_i,
    input  logic               tdi_i,
    output logic               tdo_o,
    output logic               tdo_oe_o,
    output logic [3:0]         tap_state_o,
    output logic [IrWidth-1:0] ir_o,
    output logic               user_capture_o,
    output logic               user_shift_o,
    output logic               user_update_o,
    output logic               user_tdi_o,
    input  logic               user_tdo_i
);

    logic reset_next, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;
    logic [IrWidth-1:0] ir_q, ir_d, ir_shift_q, ir_shift_d;
    logic [31:0] idcode_q, idcode_d;
    logic bypass_q, bypass_d, tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
    logic sel_idcode, sel_user;

    jtag_tap_fsm u_fsm (
        .tck_i        (tck_i),
        .trst_ni      (trst_ni),
        .tms_i        (tms_i),
        .tap_state_o  (tap_state_o),
        .reset_next_o (reset_next),
        .capture_dr_o (capture_dr),
        .shift_dr_o   (shift_dr),
        .update_dr_o  (update_dr),
        .capture_ir_o (capture_ir),
        .shift_ir_o   (shift_ir),
        .update_ir_o  (update_ir)
    );

    assign sel_idcode = ir_q == IdcodeIr;
    assign sel_user   = ir_q == UserIr;

    // ir is forced to IDCODE on the edge that enters TestLogicReset, so it already
    // reads IDCODE while the state does.
    always_comb begin
        ir_shift_d = capture_ir ? IrWidth'(IrCaptureValue)
                   : shift_ir   ? {tdi_i, ir_shift_q[IrWidth-1:1]}
                   : ir_shift_q;
        ir_d       = reset_next ? IdcodeIr : update_ir ? ir_shift_q : ir_q;
        idcode_d   = (capture_dr && sel_idcode) ? IdcodeValue
                   : shift_dr ? {tdi_i, idcode_q[31:1]}
                   : idcode_q;
        bypass_d   = capture_dr ? 1'b0 : shift_dr ? tdi_i : bypass_q;
        tdo_oe_d   = shift_ir | shift_dr;
        tdo_d      = shift_ir   ? ir_shift_q[0]
                   : !shift_dr  ? 1'b0
                   : sel_idcode ? idcode_q[0]
                   : sel_user   ? user_tdo_i
                   : bypass_q;
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            ir_q       <= IdcodeIr;
            ir_shift_q <= '0;
            idcode_q   <= '0;
            bypass_q   <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            idcode_q   <= idcode_d;
            bypass_q   <= bypass_d;
        end
    end

    always_ff @(negedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

    assign tdo_o          = tdo_q;
    assign tdo_oe_o       = tdo_oe_q;
    assign ir_o           = ir_q;
    assign user_capture_o = capture_dr & sel_user;
    assign user_shift_o   = shift_dr & sel_user;
    assign user_update_o  = update_dr & sel_user;
    assign user_tdi_o     = tdi_i;

endmodule
